// File: rtl/gpio_vector_if.sv
// CPU-side register interface of the 16-pin GPIO port.
// The master drives configuration and output data.
// The slave (the GPIO block) returns the sampled pads and the interrupt pulses.
interface gpio_vector_if;
  logic        Enable;           // active-low module enable
  logic [15:0] Function;         // 1 = output, 0 = input
  logic [15:0] Data_out;         // value for output pins
  logic [15:0] Pin_Change_Mask;  // per-pin interrupt enable
  logic [1:0]  Int_Mask;         // edge select for pins 14/15
  logic [15:0] Data_in;          // registered pad sample
  logic [15:0] Pin_out;          // registered pad drive value
  logic        IRQ_PIN_CHANGE;   // global pin-change pulse
  logic [1:0]  IRQ_INT;          // external interrupt pulses (pin 14, pin 15)

  modport master (
    output Enable, Function, Data_out, Pin_Change_Mask, Int_Mask,
    input  Data_in, Pin_out, IRQ_PIN_CHANGE, IRQ_INT
  );

  modport slave (
    input  Enable, Function, Data_out, Pin_Change_Mask, Int_Mask,
    output Data_in, Pin_out, IRQ_PIN_CHANGE, IRQ_INT
  );
endinterface

// File: rtl/gpio_vector.sv
// 16-pin GPIO port with per-pin direction, pad readback, pin-change
// interrupt and two edge-selectable external interrupts on pins 14/15.
// Every output is registered.
// The pad drive is a combinational decode of registered Pin_out.
module gpio_vector (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  inout  wire [15:0] PIN_DATA,
  gpio_vector_if.slave bus
);

  localparam int unsigned EXT_PIN0 = 14;
  localparam int unsigned EXT_PIN1 = 15;

  logic [15:0] dir_s;
  logic [15:0] pad_oe_s;

  logic [15:0] pin_out_q, pin_out_d;
  logic [15:0] data_in_q, data_in_d;
  logic [15:0] prev_q,    prev_d;
  logic        irq_pc_q,  irq_pc_d;
  logic [1:0]  irq_int_q, irq_int_d;

  // One external-interrupt decision: selected edge on an interrupt-enabled pin.
  function automatic logic ext_irq(input logic       cur,
                                   input logic       prv,
                                   input logic       pin_en,
                                   input logic [1:0] edge_sel);
    logic rise;
    logic fall;
    rise = cur & ~prv;
    fall = ~cur & prv;
    return pin_en & ((edge_sel[0] & rise) | (edge_sel[1] & fall));
  endfunction

  // Effective direction: interrupt-enabled pins 14/15 are forced to input.
  always_comb begin
    dir_s = bus.Function;
    if (bus.Pin_Change_Mask[EXT_PIN0]) begin
      dir_s[EXT_PIN0] = 1'b0;
    end else begin
      dir_s[EXT_PIN0] = bus.Function[EXT_PIN0];
    end
    if (bus.Pin_Change_Mask[EXT_PIN1]) begin
      dir_s[EXT_PIN1] = 1'b0;
    end else begin
      dir_s[EXT_PIN1] = bus.Function[EXT_PIN1];
    end
  end

  // Pad output enables: nothing is driven while disabled or held in reset.
  always_comb begin
    if (!reset || bus.Enable) begin
      pad_oe_s = 16'h0000;
    end else begin
      pad_oe_s = dir_s;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_pad
    assign PIN_DATA[gi] = pad_oe_s[gi] ? pin_out_q[gi] : 1'bz;
  end

  // Next-state: drive value, pad sample, history and interrupt pulses.
  // While disabled, every output heads to zero.
  // The interrupt pulses are also held low there, so a disable never emits a spurious edge event.
  always_comb begin
    pin_out_d = 16'h0000;
    data_in_d = 16'h0000;
    irq_pc_d  = 1'b0;
    irq_int_d = 2'b00;
    prev_d    = data_in_q;
    if (bus.Enable) begin
      pin_out_d = 16'h0000;
      data_in_d = 16'h0000;
      irq_pc_d  = 1'b0;
      irq_int_d = 2'b00;
    end else begin
      pin_out_d    = bus.Data_out & dir_s;
      data_in_d    = PIN_DATA;
      irq_pc_d     = |((data_in_q ^ prev_q) & bus.Pin_Change_Mask);
      irq_int_d[0] = ext_irq(data_in_q[EXT_PIN0], prev_q[EXT_PIN0],
                             bus.Pin_Change_Mask[EXT_PIN0], bus.Int_Mask);
      irq_int_d[1] = ext_irq(data_in_q[EXT_PIN1], prev_q[EXT_PIN1],
                             bus.Pin_Change_Mask[EXT_PIN1], bus.Int_Mask);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_out_q <= 16'h0000;
      data_in_q <= 16'h0000;
      prev_q    <= 16'h0000;
      irq_pc_q  <= 1'b0;
      irq_int_q <= 2'b00;
    end else begin
      pin_out_q <= pin_out_d;
      data_in_q <= data_in_d;
      prev_q    <= prev_d;
      irq_pc_q  <= irq_pc_d;
      irq_int_q <= irq_int_d;
    end
  end

  assign bus.Pin_out        = pin_out_q;
  assign bus.Data_in        = data_in_q;
  assign bus.IRQ_PIN_CHANGE = irq_pc_q;
  assign bus.IRQ_INT        = irq_int_q;

endmodule

// File: tb/tb_gpio_vector.sv
// Self-checking bench for gpio_vector.
// The reference model is a per-edge history of pad samples.
// Data_in is the newest entry, prev is the one before it, and the interrupts come from the two newest entries.
module tb_gpio_vector;
  logic        clk;
  logic        reset;
  wire  [15:0] pin_data;
  logic [15:0] ext_val;
  logic [15:0] ext_en;

  int checks;
  int failures;

  logic [15:0] samp_q[$];
  logic [15:0] exp_din;
  logic [15:0] exp_pout;
  logic [15:0] exp_pad;
  logic        exp_pc;
  logic [1:0]  exp_int;

  gpio_vector_if bus ();

  gpio_vector dut (
    .clk      (clk),
    .reset    (reset),
    .PIN_DATA (pin_data),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 16; gi++) begin : g_ext
    assign pin_data[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  function automatic logic [15:0] eff_dir(input logic [15:0] fn, input logic [15:0] pcm);
    logic [15:0] d;
    d = fn;
    if (pcm[14]) d[14] = 1'b0;
    if (pcm[15]) d[15] = 1'b0;
    return d;
  endfunction

  // Pins the DUT must be driving right now.
  function automatic logic [15:0] driven_mask();
    if (reset == 1'b0 || bus.Enable == 1'b1) return 16'h0000;
    return eff_dir(bus.Function, bus.Pin_Change_Mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q   = '{16'h0000, 16'h0000};
    exp_din  = 16'h0000;
    exp_pout = 16'h0000;
    exp_pc   = 1'b0;
    exp_int  = 2'b00;
  endtask

  // The external world drives every pad that the DUT leaves released.
  task automatic apply_ext(input logic [15:0] v);
    ext_val = v;
    ext_en  = ~driven_mask();
  endtask

  // Runs one clock with the inputs already set.
  // Checks the pad bus before the edge and all registered outputs after it.
  task automatic run_cycle();
    logic [15:0] drv, cur, prv, dir, pcm;
    logic [1:0]  im;
    logic        en_n;
    logic        rst_n;
    ext_en = ~driven_mask();
    #1;
    drv     = driven_mask();
    exp_pad = (exp_pout & drv) | (ext_val & ~drv);
    check("pad_bus", pin_data, exp_pad);
    en_n  = bus.Enable;
    rst_n = reset;
    pcm   = bus.Pin_Change_Mask;
    im    = bus.Int_Mask;
    dir   = eff_dir(bus.Function, pcm);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (en_n) begin
      cur      = samp_q[$];
      exp_pout = 16'h0000;
      exp_din  = 16'h0000;
      exp_pc   = 1'b0;
      exp_int  = 2'b00;
      samp_q.push_back(16'h0000);
    end else begin
      cur      = samp_q[$];
      prv      = samp_q[$-1];
      exp_pc   = ((cur ^ prv) & pcm) != 16'h0000;
      for (int k = 0; k < 2; k++) begin
        exp_int[k] = pcm[14+k] & ((im[0] & cur[14+k] & ~prv[14+k]) |
                                  (im[1] & ~cur[14+k] & prv[14+k]));
      end
      exp_pout = bus.Data_out & dir;
      exp_din  = exp_pad;
      samp_q.push_back(exp_pad);
    end
    while (samp_q.size() > 4) void'(samp_q.pop_front());
    @(negedge clk);
    check("data_in", bus.Data_in, exp_din);
    check("pin_out", bus.Pin_out, exp_pout);
    check("irq_pin_change", bus.IRQ_PIN_CHANGE, exp_pc);
    check("irq_int", bus.IRQ_INT, exp_int);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.Enable          = 1'b1;
    bus.Function        = 16'h0000;
    bus.Data_out        = 16'h0000;
    bus.Pin_Change_Mask = 16'h0000;
    bus.Int_Mask        = 2'b00;
    ext_val = 16'h0000;
    ext_en  = 16'hFFFF;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_data_in", bus.Data_in, 32'h0);
    check("rst_pin_out", bus.Pin_out, 32'h0);
    check("rst_irq_pc", bus.IRQ_PIN_CHANGE, 32'h0);
    check("rst_irq_int", bus.IRQ_INT, 32'h0);
    reset = 1'b1;
    run_cycle();

    // Mixed direction with external drive on the input pins
    bus.Enable   = 1'b0;
    bus.Function = 16'hAA55;
    bus.Data_out = 16'hFFFF;
    apply_ext(16'h5A5A);
    run_cycle();
    check("lit_din_first", bus.Data_in, 32'h0000500A);
    repeat (4) run_cycle();
    check("lit_pin_out_aa55", bus.Pin_out, 32'h0000AA55);
    check("lit_pad_fa5f", pin_data, 32'h0000FA5F);
    check("lit_din_fa5f", bus.Data_in, 32'h0000FA5F);

    // External interrupts on pins 14/15, rising edge
    bus.Function        = 16'hC000;
    bus.Pin_Change_Mask = 16'hC000;
    bus.Int_Mask        = 2'b01;
    apply_ext(16'h0000);
    repeat (3) run_cycle();
    check("lit_pin_out_forced_in", bus.Pin_out, 32'h0);
    apply_ext(16'h4000);
    run_cycle();
    check("lit_int_early", bus.IRQ_INT, 32'h0);
    run_cycle();
    check("lit_int0_rise", bus.IRQ_INT, 32'h1);
    check("lit_pc_rise", bus.IRQ_PIN_CHANGE, 32'h1);
    run_cycle();
    check("lit_int0_one_cycle", bus.IRQ_INT, 32'h0);
    check("lit_pc_one_cycle", bus.IRQ_PIN_CHANGE, 32'h0);
    apply_ext(16'hC000);
    repeat (2) run_cycle();
    check("lit_int1_rise", bus.IRQ_INT, 32'h2);

    // Falling edge select, then the same drop with rising select
    bus.Int_Mask = 2'b10;
    run_cycle();
    apply_ext(16'h8000);
    repeat (2) run_cycle();
    check("lit_int0_fall", bus.IRQ_INT, 32'h1);
    apply_ext(16'hC000);
    repeat (3) run_cycle();
    bus.Int_Mask = 2'b01;
    apply_ext(16'h8000);
    repeat (2) run_cycle();
    check("lit_fall_no_int", bus.IRQ_INT, 32'h0);
    check("lit_fall_pc_only", bus.IRQ_PIN_CHANGE, 32'h1);

    // Asynchronous reset during traffic
    bus.Function        = 16'h5555;
    bus.Data_out        = 16'hAAAA;
    bus.Pin_Change_Mask = 16'h0000;
    bus.Int_Mask        = 2'b00;
    apply_ext(16'h3333);
    repeat (3) run_cycle();
    check("lit_din_2222", bus.Data_in, 32'h00002222);
    #2;
    reset = 1'b0;
    model_reset();
    apply_ext(16'h3333);
    #1;
    check("lit_async_din", bus.Data_in, 32'h0);
    check("lit_async_pout", bus.Pin_out, 32'h0);
    check("lit_async_pc", bus.IRQ_PIN_CHANGE, 32'h0);
    check("lit_async_int", bus.IRQ_INT, 32'h0);
    @(negedge clk);
    run_cycle();
    reset = 1'b1;
    apply_ext(16'h3333);
    repeat (3) run_cycle();

    // All outputs, then disable
    bus.Function = 16'hFFFF;
    bus.Data_out = 16'hFFFF;
    apply_ext(16'h0000);
    repeat (3) run_cycle();
    check("lit_pout_ffff", bus.Pin_out, 32'h0000FFFF);
    bus.Enable = 1'b1;
    apply_ext(16'h0000);
    #1;
    check("lit_pads_released", pin_data, 32'h0);
    run_cycle();
    check("lit_pout_disabled", bus.Pin_out, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.Enable          = ($urandom_range(0, 9) == 0);
      bus.Function        = 16'($urandom());
      bus.Data_out        = 16'($urandom());
      bus.Pin_Change_Mask = 16'($urandom());
      bus.Int_Mask        = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) apply_ext(16'($urandom()));
      else apply_ext(ext_val);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_vector.md
Name: gpio_vector

Overview:
- 16-bit general-purpose I/O port with per-pin direction control, driving a shared bidirectional pad bus.
- Samples pad levels into a read register and raises pin-change interrupts.
- Pins 14 and 15 also act as dedicated external-interrupt inputs with selectable edge sensitivity.
- Sits between the CPU register file (configuration/data registers) and the chip pads.

Parameters:
- None. Width is fixed at 16 pins; the external-interrupt pins are fixed at 14 (IRQ_INT[0]) and 15 (IRQ_INT[1]).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- Enable  input  1  module enable, active-low (0 = enabled, 1 = disabled)
- Function  input  16  direction per pin: 1 = output, 0 = input
- Data_out  input  16  value to drive on output pins
- Pin_Change_Mask  input  16  per-pin interrupt enable
- Int_Mask  input  2  edge select for pins 14/15: 00 none, 01 rising, 10 falling, 11 both
- PIN_DATA  inout  16  pad bus
- Data_in  output  16  registered sample of PIN_DATA
- Pin_out  output  16  registered value driven to pads
- IRQ_PIN_CHANGE  output  1  global pin-change interrupt pulse
- IRQ_INT  output  2  external interrupt pulses: bit0 = pin 14, bit1 = pin 15

Behaviour:
- Reset (reset=0, asynchronous):
  - Data_in, Pin_out, the previous-sample register, IRQ_PIN_CHANGE and IRQ_INT all clear to 0.
  - PIN_DATA is fully tri-stated.
- Effective direction dir[i] = Function[i], except for pins 14 and 15: if Pin_Change_Mask[i]=1, dir[i]=0. Interrupt-enabled pins 14/15 are forced to input regardless of Function.
- Pin_out, registered:
  - Enable=0: Pin_out <= Data_out & dir.
  - Enable=1: Pin_out <= 0.
  - Latency: one clock.
- Pad drive (combinational from registers):
  - PIN_DATA[i] = Pin_out[i] when dir[i]=1 and Enable=0; otherwise 'z'.
  - Output pins are never driven while disabled.
- Data_in, registered each clk:
  - Enable=0: Data_in <= PIN_DATA. Output pins read back their own driven level.
  - Enable=1: Data_in <= 0.
- prev register: prev <= Data_in every clk (0 while disabled/reset).
- Pin-change interrupt:
  - IRQ_PIN_CHANGE <= |((Data_in ^ prev) & Pin_Change_Mask), registered.
  - Single-cycle pulse per detected change.
  - Responds to both edges independent of Int_Mask.
- External interrupts, for k=0 (pin 14) and k=1 (pin 15):
  - rise = Data_in[p] & ~prev[p]; fall = ~Data_in[p] & prev[p].
  - IRQ_INT[k] <= Pin_Change_Mask[p] & ((Int_Mask[0] & rise) | (Int_Mask[1] & fall)), registered.
  - Single-cycle pulse.
  - Int_Mask=00 suppresses IRQ_INT; IRQ_PIN_CHANGE is still raised.
- Latency:
  - Pad transition → Data_in: next rising edge.
  - Interrupt pulse asserts on the following edge (second edge after the pad change) and is high for exactly one cycle.
- Simultaneous changes on several masked pins produce one IRQ_PIN_CHANGE pulse. Continuous toggling keeps it high.
- Enable 0→1: all outputs reach 0 within one clock; pads tri-state immediately on the registered Pin_out/Enable path. Enable 1→0: prev starts from 0, so input pins already high generate a rising-edge event on the first sample.
- Mid-operation reset: everything clears immediately. No pulse is generated on reset release until a real change is sampled.
- Configuration inputs are used unregistered; changes take effect on the next edge.

Test Plan:
- Enable=0, Function=AA55, Data_out=FFFF, 5 cycles → Pin_out=AA55; PIN_DATA driven 1 on those bits, 'z' elsewhere.
- Same configuration, external drive 5A5A on ~Function bits → Data_in matches 5A5A on all input bits after 1 cycle.
- Function[15:14]=11, Pin_Change_Mask[15:14]=11, Int_Mask=01, external drive pins 14/15 low → Pin_out[15:14]=00 and pads released. Raise pin 14 → IRQ_INT[0] and IRQ_PIN_CHANGE each a one-cycle pulse, 2 cycles later. Raise pin 15 → IRQ_INT[1] pulses.
- Int_Mask=10, drop pin 14 → IRQ_INT[0] pulses. With Int_Mask=01, the same drop gives IRQ_PIN_CHANGE only.
- Active traffic (Function=5555, Data_out=AAAA, inputs 3333), assert reset → Data_in, Pin_out, IRQ_PIN_CHANGE, IRQ_INT all 0 immediately.
- Function=FFFF, Data_out=FFFF, Enable=0 → Pin_out=FFFF. Set Enable=1 → Pin_out=0000 within one cycle, PIN_DATA all 'z'.
